// File: rtl/fft_tile_mac.sv
`default_nettype none
// ============================================================================
// Module      : fft_tile_mac
// Description : Lane-wise complex multiply of an image and a kernel spectrum
//               tile, accumulated over a group of channels.
// Revision    : 1.0 - initial release
// ============================================================================

package fft_tile_mac_pkg;
    typedef struct packed {
        logic signed [31:0] r;
        logic signed [31:0] i;
    } complex_t;
endpackage

module fft_tile_mac
    import fft_tile_mac_pkg::*;
#(
    parameter int FRAC_BITS = 16,
    parameter int CNT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_WIDTH-1:0] num_ch,
    input  logic                 in_valid,
    input  complex_t [0:3][0:3]  image_in,
    input  complex_t [0:3][0:3]  kernel_in,
    output logic                 out_valid,
    output complex_t [0:3][0:3]  out,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

    // Full-precision complex product, rescaled by FRAC_BITS and wrapped to 32 bits.
    function automatic complex_t cmul(input complex_t a, input complex_t b);
        logic signed [63:0] m_rr, m_ii, m_ri, m_ir;
        logic signed [64:0] s_r, s_i;
        m_rr = 64'(a.r) * 64'(b.r);
        m_ii = 64'(a.i) * 64'(b.i);
        m_ri = 64'(a.r) * 64'(b.i);
        m_ir = 64'(a.i) * 64'(b.r);
        s_r  = 65'(m_rr) - 65'(m_ii);
        s_i  = 65'(m_ri) + 65'(m_ir);
        cmul.r = 32'(s_r >>> FRAC_BITS);
        cmul.i = 32'(s_i >>> FRAC_BITS);
    endfunction

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_n;
    logic [CNT_WIDTH-1:0] w_n;
    logic                 w_first;
    logic                 w_last;

    complex_t [0:3][0:3]  w_prod;
    complex_t [0:3][0:3]  r_prod;
    logic                 r_s1_valid;
    logic                 r_s1_first;
    logic                 r_s1_last;

    complex_t [0:3][0:3]  r_acc;
    complex_t [0:3][0:3]  w_acc_next;

    // The group length is only taken from num_ch on the opening beat.
    always_comb begin
        w_first = (r_count == '0);
        if (w_first) begin
            w_n = (num_ch == '0) ? C_ONE : num_ch;
        end else begin
            w_n = r_n;
        end
        w_last = (r_count == (w_n - C_ONE));
    end

    always_comb begin
        w_prod = '0;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                w_prod[rr][cc] = cmul(image_in[rr][cc], kernel_in[rr][cc]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_n        <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_prod     <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                if (w_first) begin
                    r_n <= w_n;
                end
                r_count    <= w_last ? '0 : (r_count + C_ONE);
                r_s1_first <= w_first;
                r_s1_last  <= w_last;
                r_prod     <= w_prod;
            end
        end
    end

    always_comb begin
        w_acc_next = '0;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                if (r_s1_first) begin
                    w_acc_next[rr][cc] = r_prod[rr][cc];
                end else begin
                    w_acc_next[rr][cc].r = r_acc[rr][cc].r + r_prod[rr][cc].r;
                    w_acc_next[rr][cc].i = r_acc[rr][cc].i + r_prod[rr][cc].i;
                end
            end
        end
    end

    // The result tile is published in the same edge that the accumulator closes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_s1_valid & r_s1_last;
            if (r_s1_valid) begin
                r_acc <= w_acc_next;
                if (r_s1_last) begin
                    out <= w_acc_next;
                end
            end
        end
    end

    assign busy = (r_count != '0) | r_s1_valid | out_valid;

endmodule

`default_nettype wire

// File: tb/tb_fft_tile_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_tile_mac
// Description : Scoreboard bench for fft_tile_mac with directed tiles.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_fft_tile_mac;
    import fft_tile_mac_pkg::*;

    typedef complex_t [0:3][0:3] tile_t;
    typedef struct {
        tile_t tile;
        int    cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  num_ch;
    logic        in_valid;
    tile_t       image_in;
    tile_t       kernel_in;
    logic        out_valid;
    tile_t       out;
    logic        busy;

    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t m_e;
    int   m_r, m_c;
    bit   m_found;

    fft_tile_mac #(
        .FRAC_BITS (16),
        .CNT_WIDTH (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .num_ch    (num_ch),
        .in_valid  (in_valid),
        .image_in  (image_in),
        .kernel_in (kernel_in),
        .out_valid (out_valid),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic complex_t cx(input logic [31:0] r, input logic [31:0] i);
        cx.r = r;
        cx.i = i;
    endfunction

    function automatic tile_t one(input int rr, input int cc, input complex_t v);
        one = '0;
        one[rr][cc] = v;
    endfunction

    function automatic tile_t fill(input complex_t v);
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                fill[rr][cc] = v;
    endfunction

    task automatic check1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // A beat driven at cycle c is captured at the next edge; its group result
    // must be visible at cycle c+2.
    task automatic beat(input tile_t a, input tile_t b, input logic [9:0] n,
                        input bit last, input tile_t e);
        @(negedge clk);
        in_valid  = 1'b1;
        image_in  = a;
        kernel_in = b;
        num_ch    = n;
        if (last) sb.push_back('{tile: e, cyc: cyc + 2});
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid  = 1'b0;
        image_in  = '0;
        kernel_in = '0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && sb.size() != 0; k++) idle();
        while (sb.size() != 0) begin
            void'(sb.pop_front());
            n_tests++;
            n_fail++;
            $display("FAIL %s: expected out_valid never seen", name);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: out_valid=1 at cycle %0d, required no result", cyc);
            end else begin
                m_e = sb.pop_front();
                if (m_e.cyc != cyc || out !== m_e.tile) begin
                    m_found = 1'b0;
                    m_r = 0;
                    m_c = 0;
                    for (int rr = 0; rr < 4; rr++)
                        for (int cc = 0; cc < 4; cc++)
                            if (!m_found && out[rr][cc] !== m_e.tile[rr][cc]) begin
                                m_found = 1'b1;
                                m_r = rr;
                                m_c = cc;
                            end
                    n_fail++;
                    $display("FAIL out_tile: cycle %0d (required %0d), lane [%0d][%0d] got (%h,%h) required (%h,%h)",
                             cyc, m_e.cyc, m_r, m_c, out[m_r][m_c].r, out[m_r][m_c].i,
                             m_e.tile[m_r][m_c].r, m_e.tile[m_r][m_c].i);
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        num_ch    = '0;
        image_in  = '0;
        kernel_in = '0;
        repeat (3) @(negedge clk);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_out_zero", out == '0, 1'b1);
        @(negedge clk);
        reset = 1'b1;

        // Single-channel group, one active lane, with busy timing around it.
        beat(one(0, 0, cx(32'h0001_0000, 32'h0)), one(0, 0, cx(32'h0002_8000, 32'hFFFF_0000)),
             10'd1, 1'b1, one(0, 0, cx(32'h0002_8000, 32'hFFFF_0000)));
        idle();
        check1("t1_busy_stage1", busy, 1'b1);
        idle();
        check1("t1_busy_with_out", busy, 1'b1);
        idle();
        check1("t1_busy_fall", busy, 1'b0);
        check32("t1_out_held", out[0][0].r, 32'h0002_8000);
        drain("t1");

        // Three back-to-back beats summed into one result.
        for (int k = 0; k < 3; k++)
            beat(fill(cx(32'h0001_0000, 32'h0001_0000)), fill(cx(32'h0, 32'h0001_0000)),
                 10'd3, k == 2, fill(cx(32'hFFFD_0000, 32'h0003_0000)));
        idle();
        drain("t2");

        // Gapped group (num_ch change mid-group ignored), then an immediate second group.
        beat(fill(cx(32'h0002_0000, 32'h0)), fill(cx(32'h0001_8000, 32'h0000_8000)),
             10'd2, 1'b0, '0);
        repeat (4) idle();
        check1("t3_busy_gap", busy, 1'b1);
        beat(fill(cx(32'h0002_0000, 32'h0)), fill(cx(32'h0001_8000, 32'h0000_8000)),
             10'd7, 1'b1, fill(cx(32'h0006_0000, 32'h0002_0000)));
        beat(fill(cx(32'h0001_0000, 32'h0)), fill(cx(32'h0000_8000, 32'h0)), 10'd2, 1'b0, '0);
        beat(fill(cx(32'h0001_0000, 32'h0)), fill(cx(32'h0000_8000, 32'h0)), 10'd2, 1'b1,
             fill(cx(32'h0001_0000, 32'h0)));
        idle();
        drain("t3");

        // Accumulator wraps modulo 2^32 without saturating.
        beat(one(3, 3, cx(32'h7FFF_0000, 32'h0)), one(3, 3, cx(32'h0001_0000, 32'h0)),
             10'd2, 1'b0, '0);
        beat(one(3, 3, cx(32'h7FFF_0000, 32'h0)), one(3, 3, cx(32'h0001_0000, 32'h0)),
             10'd2, 1'b1, one(3, 3, cx(32'hFFFE_0000, 32'h0)));
        idle();
        drain("t4");

        // Reset in the middle of a group discards it entirely.
        beat(fill(cx(32'h0001_0000, 32'h0)), fill(cx(32'h0001_0000, 32'h0)), 10'd4, 1'b0, '0);
        beat(fill(cx(32'h0001_0000, 32'h0)), fill(cx(32'h0001_0000, 32'h0)), 10'd4, 1'b0, '0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check1("t5_busy_after_reset", busy, 1'b0);
        check1("t5_out_valid_after_reset", out_valid, 1'b0);
        check1("t5_out_cleared", out == '0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        beat(one(2, 1, cx(32'h0001_0000, 32'h0)), one(2, 1, cx(32'h0003_0000, 32'h0001_0000)),
             10'd1, 1'b1, one(2, 1, cx(32'h0003_0000, 32'h0001_0000)));
        idle();
        drain("t5");

        // num_ch of zero acts as one: consecutive single-beat groups.
        beat(one(0, 0, cx(32'h0001_0000, 32'h0)), one(0, 0, cx(32'h0001_0000, 32'h0)),
             10'd0, 1'b1, one(0, 0, cx(32'h0001_0000, 32'h0)));
        beat(one(0, 0, cx(32'h0, 32'h0001_0000)), one(0, 0, cx(32'h0, 32'h0001_0000)),
             10'd0, 1'b1, one(0, 0, cx(32'hFFFF_0000, 32'h0)));
        idle();
        drain("t6");

        repeat (3) idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_tile_mac.md
Name: fft_tile_mac

Overview:
- Frequency-domain multiply-accumulate stage that sits directly downstream of the 4x4 2-D FFT and the kernel block memory.
- Each beat takes one 4x4 image-spectrum tile (fft4_2d out) and one 4x4 kernel-spectrum tile (kernel memory out) and forms 16 lane-wise complex products.
- Products are summed over num_ch input channels; the summed 4x4 tile is presented to the inverse-FFT stage with a one-cycle valid pulse.

Parameters:
- FRAC_BITS, 16, fixed-point fraction bits of r/i (signed Q15.16 in 32 bits).
- CNT_WIDTH, 10, width of the channel count and beat counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- num_ch  input  CNT_WIDTH  channels per group; sampled only on the first beat of a group.
- in_valid  input  1  image_in/kernel_in hold a valid beat this cycle.
- image_in  input  complex_t[0:3][0:3]  image spectrum tile.
- kernel_in  input  complex_t[0:3][0:3]  kernel spectrum tile.
- out_valid  output  1  single-cycle pulse: out holds a completed group sum.
- out  output  complex_t[0:3][0:3]  accumulated tile; held until the next completed group.
- busy  output  1  a group is partially accumulated, or a product is in flight in the pipeline.

Behaviour:
- Reset (reset=0, async): out_valid=0, out all zero, busy=0, beat counter=0, latched count=0, accumulator=0, pipeline valid bits=0. Any in-progress group is discarded.
- No input backpressure: every cycle with in_valid=1 is accepted.
- Stage 1 (register), per lane:
  - pr = a.r*b.r - a.i*b.i
  - pi = a.r*b.i + a.i*b.r
  - Products are full 64-bit signed; the sum/difference is 65-bit; arithmetic shift right by FRAC_BITS; keep low 32 bits (wrap, no saturation).
  - Stage-1 register carries flags first and last.
- Stage 2 (accumulator):
  - If first, acc <= product.
  - Otherwise acc <= acc + product, mod 2^32 per r/i.
  - If last, out <= the new acc value and out_valid=1 the same cycle the acc updates.
- Latency: last beat accepted at cycle T -> out_valid=1 and out valid at cycle T+2.
- Beat counter:
  - A beat with count==0 is first. It latches N = num_ch, with num_ch==0 treated as 1.
  - A beat is last when count==N-1; count then returns to 0, else count increments.
  - num_ch changes mid-group are ignored.
  - With N==1, every beat is both first and last.
- Back-to-back groups need no idle cycle: a first beat reloads acc while the previous last beat's result sits in out.
- Gaps (in_valid=0) inside a group: acc and count hold, and no stage-1 valid is produced.
- busy = (count != 0) OR stage-1 valid OR stage-2 update pending; it falls one cycle after out_valid when no new beat arrives.
- out_valid never stays high two consecutive cycles unless two groups complete on consecutive cycles, which requires N==1.

Test Plan:
- num_ch=1; image lane[0][0]=(1.0,0) (0x00010000,0); kernel lane[0][0]=(2.5,-1.0) (0x00028000,0xFFFF0000); other lanes 0 -> out_valid at T+2; out[0][0]=(0x00028000,0xFFFF0000); other lanes 0.
- num_ch=3; three consecutive beats, all lanes image=(1.0,1.0), kernel=(0,1.0) -> each product is (-1.0,1.0); single out_valid 2 cycles after beat 3; all lanes (0xFFFD0000,0x00030000).
- num_ch=2 with 4 idle cycles between beats, then an immediate second group of num_ch=2 with product 0.5 -> two out_valid pulses; second result is 1.0 (0x00010000), no carry-over from group 1.
- Wrap: num_ch=2, each product r=0x7FFF0000 -> out r=0xFFFE0000; no saturation.
- reset driven to 0 after beat 2 of a num_ch=4 group, then released, then a fresh num_ch=1 beat -> no out_valid for the aborted group; busy=0 right after reset; fresh group result correct at T+2.
- num_ch=0 with two beats -> behaves as N=1: two out_valid pulses on consecutive cycles, each equal to its own product.
